fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Multi-cycle instruction fetch and sequencing unit for the basic processor. It fetches 16-bit instructions from instruction memory over a request/acknowledge handshake and holds them in an instruction register. It presents the opcode and register fields to the control decoder, then consumes the decoder's BRANCH and HALT outputs and the ALU zero flag to start execution and compute the next PC. It sits between instruction memory, the control decoder and the datapath, and owns the processor's PC and run/halt state.

## Interface
- PC_WIDTH, 8, PC and instruction-memory address width
- RESET_PC, 0, PC value loaded on reset
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- RUN  in  1  start request; sampled only in IDLE
- IMEM_ADDR  out  PC_WIDTH  fetch address (= PC)
- IMEM_REQ  out  1  fetch request
- IMEM_ACK  in  1  fetch complete; IMEM_DATA valid this cycle
- IMEM_DATA  in  16  fetched instruction
- OPCODE  out  4  IR[15:12], to control decoder
- RA, RB, RC  out  3 each  IR[11:9], IR[8:6], IR[5:3]
- IMM3  out  3  IR[2:0]
- HALT_IN  in  1  decoder HALT
- BRANCH_IN  in  1  decoder BRANCH
- ZERO  in  1  ALU zero flag
- EXEC_START  out  1  one-cycle pulse: datapath may act on current instruction
- EXEC_DONE  in  1  datapath finished current instruction
- PC  out  PC_WIDTH  current program counter
- HALTED  out  1  processor stopped
- INSTR_COUNT  out  16  retired instructions, saturating

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALTED.
- IDLE: RUN=1 -> FETCH; else stay.
- FETCH: IMEM_REQ=1, IMEM_ADDR=PC, held until IMEM_ACK. On ACK, IR <= IMEM_DATA and next state is DECODE. ACK outside FETCH is ignored.
- DECODE: one cycle; decoder outputs settle from registered OPCODE. HALT_IN=1 -> HALTED, with PC and INSTR_COUNT unchanged. Otherwise -> EXEC.
- EXEC: EXEC_START=1 in the first EXEC cycle only (registered). Stay until EXEC_DONE=1; DONE may arrive in that first cycle. On the DONE cycle:
  - If BRANCH_IN & ZERO: PC <= PC + 1 + sign_extend(IR[5:0]).
  - Otherwise: PC <= PC + 1.
  - INSTR_COUNT += 1, unless it is 16'hFFFF.
  - Next state is FETCH.
- HALTED: HALTED=1; leaves only via RST. RUN is ignored.
- Arithmetic is modulo 2^PC_WIDTH. The 6-bit offset is sign-extended to PC_WIDTH, and both increment and branch target wrap silently.
- BRANCH_IN and ZERO are sampled only in the EXEC_DONE cycle. HALT_IN is sampled only in DECODE.

## Timing
- Reset values (next edge with RST=1, from any state including mid-FETCH/EXEC):
  - state IDLE, PC=RESET_PC, IR=16'hF000 (OPCODE=15, harmless halt encoding)
  - IMEM_REQ=0, EXEC_START=0, HALTED=0, INSTR_COUNT=0
- RST has priority over RUN, ACK, DONE in the same cycle. A pending fetch or execution is abandoned; no PC or count update occurs.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- Minimum cycles per instruction: 3 (FETCH with same-cycle ACK, DECODE, EXEC with same-cycle DONE).
- Each wait cycle on ACK or DONE adds one cycle.
- PC/IMEM_ADDR change on the edge that leaves EXEC. The next FETCH presents the new address in its first cycle.
- IMEM_REQ rises in the first FETCH cycle and falls on the edge that captures ACK.

## Test plan
- Reset: assert RST for 2 cycles with RUN=1 -> all outputs at reset values, OPCODE=15, state IDLE.
- Straight-line: RUN=1, ACK and DONE every cycle, memory holds opcodes 1,1,2 -> PC 0->1->2->3, EXEC_START pulses exactly once per instruction 3 cycles apart, INSTR_COUNT=3.
- Branch:
  - At PC=10, IR=16'h303E (offset -2), BRANCH_IN=1, ZERO=1 -> PC=9.
  - Same instruction with ZERO=0 -> PC=11.
  - At PC=255, offset +1, branch taken -> PC=1 (wrap).
- Handshake stalls: ACK delayed 3 cycles and DONE delayed 2 cycles -> IMEM_REQ held 4 cycles, EXEC_START high 1 cycle only, instruction takes 7 cycles. A stray ACK during EXEC is ignored.
- Halt: opcode 15 at PC=4 -> HALTED=1 two cycles after ACK, PC stays 4, count not incremented. RUN pulses are ignored until RST.
- Reset mid-EXEC: RST asserted while in EXEC with DONE=1 in the same cycle -> PC=RESET_PC, INSTR_COUNT=0, no increment applied.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch/decode/execute sequencer for the basic
// processor. Owns the PC, the instruction register, the run/halt state and
// the retired-instruction counter. Every output comes straight from a
// register, so there is no combinational path from any input to any output.
module fetch_sequencer #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RUN,
  output logic [PC_WIDTH-1:0] IMEM_ADDR,
  output logic                IMEM_REQ,
  input  logic                IMEM_ACK,
  input  logic [15:0]         IMEM_DATA,
  output logic [3:0]          OPCODE,
  output logic [2:0]          RA,
  output logic [2:0]          RB,
  output logic [2:0]          RC,
  output logic [2:0]          IMM3,
  input  logic                HALT_IN,
  input  logic                BRANCH_IN,
  input  logic                ZERO,
  output logic                EXEC_START,
  input  logic                EXEC_DONE,
  output logic [PC_WIDTH-1:0] PC,
  output logic                HALTED,
  output logic [15:0]         INSTR_COUNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALTED
  } state_e;

  // Opcode 15 is the halt encoding, so a freshly reset IR is harmless.
  localparam logic [15:0] IR_RESET = 16'hF000;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [15:0]         count_q, count_d;
  logic                exec_start_q, exec_start_d;

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] br_offset;

  // Six-bit branch offset sign-extended to the PC width (PC_WIDTH > 6).
  assign br_offset = {{(PC_WIDTH-6){ir_q[5]}}, ir_q[5:0]};
  assign pc_inc    = pc_q + PC_WIDTH'(1);

  // Next-state, next-PC, IR capture and retire-count logic.
  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    count_d      = count_q;
    exec_start_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (RUN) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (IMEM_ACK) begin
          ir_d    = IMEM_DATA;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (HALT_IN) begin
          state_d = S_HALTED;
        end else begin
          state_d      = S_EXEC;
          exec_start_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (EXEC_DONE) begin
          pc_d    = (BRANCH_IN && ZERO) ? pc_inc + br_offset : pc_inc;
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          state_d = S_FETCH;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset abandons any pending work.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (RST) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= IR_RESET;
      count_q      <= '0;
      exec_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      count_q      <= count_d;
      exec_start_q <= exec_start_d;
    end
  end

  assign IMEM_ADDR   = pc_q;
  assign IMEM_REQ    = (state_q == S_FETCH);
  assign HALTED      = (state_q == S_HALTED);
  assign EXEC_START  = exec_start_q;
  assign PC          = pc_q;
  assign INSTR_COUNT = count_q;
  assign OPCODE      = ir_q[15:12];
  assign RA          = ir_q[11:9];
  assign RB          = ir_q[8:6];
  assign RC          = ir_q[5:3];
  assign IMM3        = ir_q[2:0];

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, straight-line code, branches
// (taken, not taken, wrap), handshake stalls, halt and reset mid-execution.
module tb_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RUN;
  logic [7:0]  IMEM_ADDR;
  logic        IMEM_REQ;
  logic        IMEM_ACK;
  logic [15:0] IMEM_DATA;
  logic [3:0]  OPCODE;
  logic [2:0]  RA, RB, RC, IMM3;
  logic        HALT_IN, BRANCH_IN, ZERO;
  logic        EXEC_START;
  logic        EXEC_DONE;
  logic [7:0]  PC;
  logic        HALTED;
  logic [15:0] INSTR_COUNT;

  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;
  int req_cnt, es_cnt;

  fetch_sequencer #(.PC_WIDTH(8), .RESET_PC(8'd0)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN),
    .IMEM_ADDR(IMEM_ADDR), .IMEM_REQ(IMEM_REQ), .IMEM_ACK(IMEM_ACK),
    .IMEM_DATA(IMEM_DATA), .OPCODE(OPCODE), .RA(RA), .RB(RB), .RC(RC),
    .IMM3(IMM3), .HALT_IN(HALT_IN), .BRANCH_IN(BRANCH_IN), .ZERO(ZERO),
    .EXEC_START(EXEC_START), .EXEC_DONE(EXEC_DONE), .PC(PC),
    .HALTED(HALTED), .INSTR_COUNT(INSTR_COUNT)
  );

  always #5 CLK = ~CLK;

  // Instruction memory and a minimal decoder: opcode 3 branches, 15 halts.
  assign IMEM_DATA = mem[IMEM_ADDR];
  assign BRANCH_IN = (OPCODE == 4'h3);
  assign HALT_IN   = (OPCODE == 4'hF);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000;
    mem[2]   = 16'h2000;
    mem[3]   = 16'h3006;   // branch +6: 3+1+6 = 10
    mem[10]  = 16'h303E;   // branch -2
    mem[11]  = 16'h3033;   // branch -13: 11+1-13 = 255
    mem[255] = 16'h3001;   // branch +1: 255+1+1 wraps to 1
    RST = 1'b1; RUN = 1'b1; IMEM_ACK = 1'b0; EXEC_DONE = 1'b0; ZERO = 1'b1;

    // Reset held two cycles with RUN asserted.
    step(); step();
    check("rst_pc",     32'(PC), 0);
    check("rst_req",    32'(IMEM_REQ), 0);
    check("rst_estart", 32'(EXEC_START), 0);
    check("rst_halted", 32'(HALTED), 0);
    check("rst_count",  32'(INSTR_COUNT), 0);
    check("rst_opcode", 32'(OPCODE), 15);
    RST = 1'b0; RUN = 1'b0;
    step();
    check("idle_req", 32'(IMEM_REQ), 0);

    // Straight-line code, ACK and DONE every cycle.
    IMEM_ACK = 1'b1; EXEC_DONE = 1'b1; RUN = 1'b1;
    step();
    RUN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sl_addr", 32'(IMEM_ADDR), 32'(i));
      check("sl_req",  32'(IMEM_REQ), 1);
      step();
      check("sl_opcode",   32'(OPCODE), (i == 2) ? 2 : 1);
      check("sl_estart_d", 32'(EXEC_START), 0);
      step();
      check("sl_estart_e", 32'(EXEC_START), 1);
      check("sl_pc_e",     32'(PC), 32'(i));
      step();
    end
    check("sl_pc",     32'(PC), 3);
    check("sl_count",  32'(INSTR_COUNT), 3);
    check("sl_estart", 32'(EXEC_START), 0);

    // Forward branch to 10, then the -2 branch taken and not taken.
    step(); step(); step();
    check("br_fwd", 32'(PC), 10);
    step(); step(); step();
    check("br_taken", 32'(PC), 9);
    step(); step(); step();
    check("br_back10", 32'(PC), 10);
    ZERO = 1'b0;
    step(); step(); step();
    check("br_not_taken", 32'(PC), 11);
    ZERO = 1'b1;
    step(); step(); step();
    check("br_to255", 32'(PC), 255);
    step(); step(); step();
    check("br_wrap",  32'(PC), 1);
    check("br_count", 32'(INSTR_COUNT), 9);

    // Stalls: ACK in 4th FETCH cycle, stray ACK in first EXEC cycle,
    // DONE in 2nd EXEC cycle; new FETCH begins 7 cycles later.
    req_cnt = 0; es_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      if (IMEM_REQ) req_cnt++;
      if (EXEC_START) es_cnt++;
      if (c == 5) mem[1] = 16'h2A00;
      IMEM_ACK  = (c == 3) || (c == 5);
      EXEC_DONE = (c == 6);
      step();
    end
    IMEM_ACK = 1'b0; EXEC_DONE = 1'b0;
    check("st_req_cycles",  32'(req_cnt), 4);
    check("st_es_cycles",   32'(es_cnt), 1);
    check("st_stray_ack",   32'(OPCODE), 1);
    check("st_pc",          32'(PC), 2);
    check("st_refetch_req", 32'(IMEM_REQ), 1);
    check("st_count",       32'(INSTR_COUNT), 10);

    // Halt at PC=4.
    mem[2] = 16'h1000; mem[3] = 16'h1000; mem[4] = 16'hF000;
    IMEM_ACK = 1'b1; EXEC_DONE = 1'b1;
    repeat (6) step();
    check("h_pc_before", 32'(PC), 4);
    step();
    check("h_decode_not_halted", 32'(HALTED), 0);
    step();
    check("h_halted", 32'(HALTED), 1);
    check("h_pc",     32'(PC), 4);
    check("h_count",  32'(INSTR_COUNT), 12);
    check("h_req",    32'(IMEM_REQ), 0);
    check("h_estart", 32'(EXEC_START), 0);
    RUN = 1'b1; step();
    RUN = 1'b0; step(); step();
    check("h_run_ignored", 32'(HALTED), 1);
    check("h_run_req",     32'(IMEM_REQ), 0);
    check("h_run_pc",      32'(PC), 4);

    // Reset out of HALTED, then reset mid-EXEC with DONE in the same cycle.
    RST = 1'b1; step();
    RST = 1'b0;
    check("r2_halted", 32'(HALTED), 0);
    check("r2_pc",     32'(PC), 0);
    check("r2_count",  32'(INSTR_COUNT), 0);
    mem[0] = 16'h1000; mem[1] = 16'h1000;
    RUN = 1'b1; step();
    RUN = 1'b0; step(); step(); step();
    check("rx_pc1",    32'(PC), 1);
    check("rx_count1", 32'(INSTR_COUNT), 1);
    step(); step();
    check("rx_in_exec", 32'(EXEC_START), 1);
    RST = 1'b1; step();
    RST = 1'b0;
    check("rx_pc",     32'(PC), 0);
    check("rx_count",  32'(INSTR_COUNT), 0);
    check("rx_estart", 32'(EXEC_START), 0);
    check("rx_req",    32'(IMEM_REQ), 0);
    check("rx_opcode", 32'(OPCODE), 15);
    step();
    check("rx_idle_req", 32'(IMEM_REQ), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
